// File: rtl/score_grader.sv
// score_grader: accumulates per-note timing error over a song and grades it.
// It also drives a two-digit display code ({p1,p0}) for the grade.
// The optional perfect-note streak tracker is enabled with `define SCORE_COMBO_EN.
// Without that macro, combo and max_combo are tied to zero.
// The display-code macros are defaulted here unless a shared header defines them first.

`ifndef SCORE_DISP_CODES
`define SCORE_DISP_CODES
`define SCORE_DISP_GOOD  10'h0C1
`define SCORE_DISP_NORM  10'h1A2
`define SCORE_DISP_BAD   10'h2B3
`define SCORE_DISP_BLANK 10'h3FF
`endif

module score_grader #(
  parameter int              ERR_W      = 32,
  parameter int              ACC_W      = 41,
  parameter int              CNT_W      = 12,
  parameter longint unsigned NORM_TH    = 64'd6_000_000_000,
  parameter longint unsigned BAD_TH     = 64'd10_000_000_000,
  parameter logic [9:0]      CODE_GOOD  = `SCORE_DISP_GOOD,
  parameter logic [9:0]      CODE_NORM  = `SCORE_DISP_NORM,
  parameter logic [9:0]      CODE_BAD   = `SCORE_DISP_BAD,
  parameter logic [9:0]      CODE_BLANK = `SCORE_DISP_BLANK,
  parameter longint unsigned PERFECT_TH = 64'd5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             note_valid,
  input  logic [ERR_W-1:0] note_err,
  input  logic             song_end,
  input  logic             ack,
  output logic             busy,
  output logic             grade_valid,
  output logic [1:0]       grade,
  output logic [ACC_W-1:0] total,
  output logic [CNT_W-1:0] note_cnt,
  output logic [4:0]       p0,
  output logic [4:0]       p1,
  output logic [CNT_W-1:0] combo,
  output logic [CNT_W-1:0] max_combo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GRADE, S_HOLD} state_e;
  typedef enum logic [1:0] {GR_NONE, GR_GOOD, GR_NORM, GR_BAD} grade_e;

  // A threshold that does not fit the accumulator could never be compared faithfully.
  if ((NORM_TH >> ACC_W) != 0) begin : g_norm_th_range
    $error("score_grader: NORM_TH exceeds ACC_W range");
  end
  if ((BAD_TH >> ACC_W) != 0) begin : g_bad_th_range
    $error("score_grader: BAD_TH exceeds ACC_W range");
  end

  localparam logic [ACC_W-1:0] NORM_TH_A = ACC_W'(NORM_TH);
  localparam logic [ACC_W-1:0] BAD_TH_A  = ACC_W'(BAD_TH);
  // The sum gets one spare bit so an overflow past all-ones can be detected.
  localparam int SUM_W = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grade_q, grade_d;
  logic [9:0]       code_q, code_d;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] total_sat;
  grade_e           grade_calc;
  logic [9:0]       code_calc;
  logic             run_note;
  logic             song_start;

  assign run_note   = (state_q == S_RUN) && note_valid;
  assign song_start = ((state_q == S_IDLE) || (state_q == S_HOLD)) && start;

  // Next-state logic for the song lifecycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (song_end) state_d = S_GRADE;
      S_GRADE: state_d = S_HOLD;
      S_HOLD: begin
        if (start)    state_d = S_RUN;
        else if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating error accumulation.
  always_comb begin
    sum       = SUM_W'(total_q) + SUM_W'(note_err);
    total_sat = (sum > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  // Grade and display code from the accumulated error of the finished song.
  always_comb begin
    grade_calc = GR_GOOD;
    code_calc  = CODE_GOOD;
    if (cnt_q == '0) begin
      grade_calc = GR_NONE;
      code_calc  = CODE_BLANK;
    end else if (total_q >= BAD_TH_A) begin
      grade_calc = GR_BAD;
      code_calc  = CODE_BAD;
    end else if (total_q > NORM_TH_A) begin
      grade_calc = GR_NORM;
      code_calc  = CODE_NORM;
    end
  end

  // Datapath next-state: clear on start, accumulate in RUN, latch grade on leaving GRADE.
  always_comb begin
    total_d = total_q;
    cnt_d   = cnt_q;
    grade_d = grade_q;
    code_d  = code_q;
    if (song_start) begin
      total_d = '0;
      cnt_d   = '0;
      grade_d = GR_NONE;
    end else if (run_note) begin
      total_d = total_sat;
      cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end else if (state_q == S_GRADE) begin
      grade_d = grade_calc;
      code_d  = code_calc;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      total_q <= '0;
      cnt_q   <= '0;
      grade_q <= GR_NONE;
      code_q  <= CODE_BLANK;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      grade_q <= grade_d;
      code_q  <= code_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_GRADE);
  assign grade_valid = (state_q == S_HOLD);
  assign grade       = grade_q;
  assign total       = total_q;
  assign note_cnt    = cnt_q;
  assign p1          = code_q[9:5];
  assign p0          = code_q[4:0];

`ifdef SCORE_COMBO_EN
  logic [CNT_W-1:0] combo_q, combo_d, max_q, max_d;
  logic             perfect;

  assign perfect = 64'(note_err) < PERFECT_TH;

  // Perfect-note streak: grows on perfect notes, breaks on any other note.
  always_comb begin
    combo_d = combo_q;
    max_d   = max_q;
    if (song_start) begin
      combo_d = '0;
    end else if (run_note) begin
      if (perfect) combo_d = (combo_q == {CNT_W{1'b1}}) ? combo_q : combo_q + 1'b1;
      else         combo_d = '0;
    end
    if (combo_d > max_q) max_d = combo_d;
  end

  // Streak registers; the best streak survives song restarts until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      combo_q <= '0;
      max_q   <= '0;
    end else begin
      combo_q <= combo_d;
      max_q   <= max_d;
    end
  end

  assign combo     = combo_q;
  assign max_combo = max_q;
`else
  assign combo     = '0;
  assign max_combo = '0;
`endif

endmodule

// File: tb/tb_score_grader.sv
// Self-checking bench for score_grader: a song-level reference model is compared every
// cycle, and directed songs pin the model with hand-computed results.
// A second narrow instance (ACC_W=8) exercises the saturation of total and note_cnt.
// When SCORE_COMBO_EN is defined, the perfect-streak expectations are exercised.

module tb_score_grader;

  localparam logic [9:0] GOOD  = 10'h0C1;
  localparam logic [9:0] NORM  = 10'h1A2;
  localparam logic [9:0] BAD   = 10'h2B3;
  localparam logic [9:0] BLANK = 10'h3FF;
  localparam longint unsigned MAX_TOT = (64'd1 << 41) - 1;
  localparam longint unsigned MAX_CNT = 4095;

  logic clk = 0, rst = 1, start = 0, note_valid = 0, song_end = 0, ack = 0;
  logic [31:0] note_err = 0;
  logic        busy, grade_valid;
  logic [1:0]  grade;
  logic [40:0] total;
  logic [11:0] note_cnt, combo, max_combo;
  logic [4:0]  p0, p1;

  logic [7:0]  err8;
  logic        busy8, gv8;
  logic [1:0]  grade8;
  logic [7:0]  total8;
  logic [3:0]  cnt8, combo8, max8;
  logic [4:0]  p0_8, p1_8;

  int errors = 0, checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;
  assign err8 = note_err[7:0];

  score_grader dut (
    .clk(clk), .rst(rst), .start(start), .note_valid(note_valid), .note_err(note_err),
    .song_end(song_end), .ack(ack), .busy(busy), .grade_valid(grade_valid), .grade(grade),
    .total(total), .note_cnt(note_cnt), .p0(p0), .p1(p1), .combo(combo), .max_combo(max_combo));

  score_grader #(.ERR_W(8), .ACC_W(8), .CNT_W(4), .NORM_TH(100), .BAD_TH(200), .PERFECT_TH(10)) dut8 (
    .clk(clk), .rst(rst), .start(start), .note_valid(note_valid), .note_err(err8),
    .song_end(song_end), .ack(ack), .busy(busy8), .grade_valid(gv8), .grade(grade8),
    .total(total8), .note_cnt(cnt8), .p0(p0_8), .p1(p1_8), .combo(combo8), .max_combo(max8));

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: one song at a time ----------------
  bit m_song, m_due, m_hold;
  longint unsigned m_total, m_cnt, m_combo, m_max;
  int unsigned m_grade;
  logic [9:0] m_code;

  function automatic longint unsigned sat_inc(input longint unsigned v);
    return (v == MAX_CNT) ? v : v + 1;
  endfunction

  function automatic longint unsigned max2(input longint unsigned a, input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_song <= 0; m_due <= 0; m_hold <= 0;
      m_total <= 0; m_cnt <= 0; m_combo <= 0; m_max <= 0;
      m_grade <= 0; m_code <= BLANK;
    end else if (m_song) begin
      if (note_valid) begin
        m_total <= (m_total + note_err > MAX_TOT) ? MAX_TOT : m_total + note_err;
        m_cnt   <= sat_inc(m_cnt);
`ifdef SCORE_COMBO_EN
        if (note_err < 5_000_000) begin
          m_combo <= sat_inc(m_combo);
          m_max   <= max2(m_max, sat_inc(m_combo));
        end else begin
          m_combo <= 0;
        end
`endif
      end
      if (song_end) begin
        m_song <= 0;
        m_due  <= 1;
      end
    end else if (m_due) begin
      m_due  <= 0;
      m_hold <= 1;
      if (m_cnt == 0)                          begin m_grade <= 0; m_code <= BLANK; end
      else if (m_total >= 64'd10_000_000_000)  begin m_grade <= 3; m_code <= BAD;   end
      else if (m_total > 64'd6_000_000_000)    begin m_grade <= 2; m_code <= NORM;  end
      else                                     begin m_grade <= 1; m_code <= GOOD;  end
    end else if (start) begin
      m_song <= 1; m_hold <= 0;
      m_total <= 0; m_cnt <= 0; m_combo <= 0; m_grade <= 0;
    end else if (m_hold && ack) begin
      m_hold <= 0;
    end
  end

  // Every-cycle comparison on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_song | m_due);
      check("grade_valid", grade_valid, m_hold);
      check("grade", grade, m_grade);
      check("total", total, m_total);
      check("note_cnt", note_cnt, m_cnt);
      check("p1p0", {p1, p0}, m_code);
      check("combo", combo, m_combo);
      check("max_combo", max_combo, m_max);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic note(input logic [31:0] e);
    note_valid = 1; note_err = e; tick(); note_valid = 0; note_err = 0;
  endtask

  task automatic end_song(input bit with_note, input logic [31:0] e);
    song_end = 1; note_valid = with_note; note_err = e;
    tick();
    song_end = 0; note_valid = 0; note_err = 0;
  endtask

  // Cycles from the song_end cycle to the first grade_valid cycle, bounded.
  task automatic wait_grade(output int lat);
    lat = 1;
    while (!grade_valid && lat < 10) begin
      tick();
      lat++;
    end
    if (!grade_valid) check("grade_timeout", 0, 1);
  endtask

  task automatic do_ack();
    ack = 1; tick(); ack = 0;
  endtask

  int lat;

  initial begin
    tick(); tick();
    rst = 0;
    chk_en = 1;
    check("rst_code", {p1, p0}, BLANK);
    check("rst_busy", busy, 0);

    // Notes outside RUN are ignored.
    note(32'd7);
    check("idle_note_ignored", note_cnt, 0);

    // Three 1e9 notes: GOOD, 2-cycle grade latency.
    pulse_start();
    repeat (3) note(32'd1_000_000_000);
    end_song(0, 0);
    wait_grade(lat);
    check("song1_latency", lat, 2);
    check("song1_total", total, 64'd3_000_000_000);
    check("song1_cnt", note_cnt, 3);
    check("song1_grade", grade, 1);
    check("song1_code", {p1, p0}, GOOD);
    tick(); tick();
    check("hold_stable_total", total, 64'd3_000_000_000);
    do_ack();
    check("idle_after_ack", grade_valid, 0);
    check("idle_keeps_grade", grade, 1);

    // Exactly 6e9 -> GOOD (start in RUN ignored mid-song).
    pulse_start();
    note(32'd2_000_000_000);
    pulse_start();
    note(32'd2_000_000_000);
    end_song(1, 32'd2_000_000_000);
    wait_grade(lat);
    check("6e9_total", total, 64'd6_000_000_000);
    check("6e9_grade", grade, 1);

    // 6e9+1 -> NORMAL, started straight from HOLD.
    pulse_start();
    check("hold_start_clears", total, 0);
    repeat (3) note(32'd2_000_000_000);
    note(32'd1);
    end_song(0, 0);
    wait_grade(lat);
    check("6e9p1_grade", grade, 2);
    check("6e9p1_code", {p1, p0}, NORM);

    // Exactly 1e10 -> BAD.
    pulse_start();
    repeat (5) note(32'd2_000_000_000);
    end_song(0, 0);
    wait_grade(lat);
    check("1e10_total", total, 64'd10_000_000_000);
    check("1e10_grade", grade, 3);
    check("1e10_code", {p1, p0}, BAD);

    // Empty song -> NONE / blank.
    pulse_start();
    end_song(0, 0);
    wait_grade(lat);
    check("empty_grade", grade, 0);
    check("empty_code", {p1, p0}, BLANK);
    do_ack();

    // Narrow instance: 200 then 100 on the song_end cycle saturates total at 255.
    pulse_start();
    note(32'd200);
    end_song(1, 32'd100);
    wait_grade(lat);
    check("acc8_total", total8, 255);
    check("acc8_cnt", cnt8, 2);
    check("acc8_grade", grade8, 3);
    check("main_same_cycle_note", total, 300);

    // Narrow instance: 17 notes saturate the 4-bit counter.
    pulse_start();
    repeat (17) note(32'd1);
    end_song(0, 0);
    wait_grade(lat);
    check("cnt8_sat", cnt8, 15);
    check("cnt8_total", total8, 17);
    do_ack();

    // Reset mid-song discards everything.
    pulse_start();
    note(32'd1_000_000_000);
    note(32'd1_000_000_000);
    rst = 1; tick(); rst = 0;
    check("midrst_busy", busy, 0);
    check("midrst_total", total, 0);
    check("midrst_cnt", note_cnt, 0);
    check("midrst_grade", grade, 0);
    check("midrst_code", {p1, p0}, BLANK);
    tick(); tick();
    check("midrst_no_grade", grade_valid, 0);
    pulse_start();
    note(32'd1_000_000_000);
    end_song(0, 0);
    wait_grade(lat);
    check("clean_total", total, 64'd1_000_000_000);
    check("clean_grade", grade, 1);

    // Perfect-note streak.
    pulse_start();
    note(32'd1_000_000);
    note(32'd1_000_000);
    note(32'd9_000_000);
    note(32'd1_000_000);
    end_song(0, 0);
    wait_grade(lat);
`ifdef SCORE_COMBO_EN
    check("combo_final", combo, 1);
    check("max_combo_final", max_combo, 2);
`else
    check("combo_off", combo, 0);
    check("max_combo_off", max_combo, 0);
`endif
    do_ack();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
